// File: rtl/ring_mon_pkg.sv
// Shared encodings for the ring counter monitor: FSM states, fault codes, phase indices.
// Also holds the rotation-order rule used by the monitor FSM.
package ring_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_ONEHOT = 2'b01;
  localparam logic [1:0] FC_ORDER  = 2'b10;
  localparam logic [1:0] FC_TAP    = 2'b11;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_1    = 2'd1;
  localparam logic [1:0] PH_2    = 2'd2;
  localparam logic [1:0] PH_3    = 2'd3;

  // Only forward single steps are legal; PH_NONE on either side is never legal.
  function automatic logic is_legal(input logic [1:0] p, input logic [1:0] c);
    return ((p == PH_1) && (c == PH_2)) ||
           ((p == PH_2) && (c == PH_3)) ||
           ((p == PH_3) && (c == PH_1));
  endfunction

endpackage

// File: rtl/ring_phase_decode.sv
// Combinational decode of the three ring lines into a one-hot flag and a phase index.
module ring_phase_decode
  import ring_mon_pkg::*;
(
  input  logic       i_l1,
  input  logic       i_l2,
  input  logic       i_l3,
  output logic       o_onehot,
  output logic [1:0] o_phase
);

  always_comb begin
    o_onehot = (i_l1 ^ i_l2 ^ i_l3) & ~(i_l1 & i_l2 & i_l3);
    o_phase  = PH_NONE;
    if (o_onehot) begin
      if (i_l1)      o_phase = PH_1;
      else if (i_l2) o_phase = PH_2;
      else           o_phase = PH_3;
    end
  end

endmodule

// File: rtl/ring_monitor.sv
// Ring counter health monitor: decodes phase, locks after LOCK_N legal steps,
// counts rotations while locked and latches a sticky fault code on any violation.
module ring_monitor
  import ring_mon_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L1,
  input  logic             L2,
  input  logic             L3,
  input  logic             L4,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] rot_count
);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_good, w_good_nxt, w_good_inc;
  logic [1:0]       r_prev, r_phase, r_code, w_code_nxt, w_phase;
  logic             r_prev_l3, r_locked, r_fault, w_onehot, w_legal;
  logic [CNT_W-1:0] r_rot, w_rot_nxt;

  ring_phase_decode u_dec (
    .i_l1    (L1),
    .i_l2    (L2),
    .i_l3    (L3),
    .o_onehot(w_onehot),
    .o_phase (w_phase)
  );

  assign w_legal    = is_legal(r_prev, w_phase);
  assign w_good_inc = r_good + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_code_nxt  = r_code;
    w_rot_nxt   = r_rot;
    unique case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_nxt = SYNC;
          w_good_nxt  = 4'd0;
        end
      end
      SYNC: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
          w_good_nxt  = 4'd0;
        end else if (w_legal) begin
          w_good_nxt = w_good_inc;
          if (w_good_inc == 4'(LOCK_N)) w_state_nxt = LOCKED;
        end else begin
          w_good_nxt = 4'd0;
        end
      end
      LOCKED: begin
        // Checks are priority ordered; the first hit is the latched code.
        if (!w_onehot) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_ONEHOT;
        end else if (!w_legal) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_ORDER;
        end else if (L4 != r_prev_l3) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_TAP;
        end else if (r_prev == PH_3) begin
          w_rot_nxt = r_rot + CNT_W'(1);
        end
      end
      FAULT: ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_good    <= 4'd0;
      r_prev    <= PH_NONE;
      r_prev_l3 <= 1'b0;
      r_phase   <= PH_NONE;
      r_locked  <= 1'b0;
      r_fault   <= 1'b0;
      r_code    <= FC_NONE;
      r_rot     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_good    <= w_good_nxt;
      r_prev    <= w_phase;
      r_prev_l3 <= L3;
      r_phase   <= w_phase;
      r_locked  <= (w_state_nxt == LOCKED);
      r_fault   <= (w_state_nxt == FAULT);
      r_code    <= w_code_nxt;
      r_rot     <= w_rot_nxt;
    end
  end

  assign phase      = r_phase;
  assign locked     = r_locked;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign rot_count  = r_rot;

endmodule

// File: tb/tb_ring_monitor.sv
// Scoreboard bench for ring_monitor: two instances (2-bit and 8-bit counters) share inputs
// and are checked every cycle against a behavioural model of the monitor rules.
module tb_ring_monitor;

  logic clk = 1'b0;
  logic reset, L1, L2, L3, L4;
  logic [1:0] ph_a, fc_a, ph_b, fc_b;
  logic       lk_a, ft_a, lk_b, ft_b;
  logic [1:0] rot_a;
  logic [7:0] rot_b;

  always #5 clk = ~clk;

  ring_monitor #(.CNT_W(2), .LOCK_N(3)) u_dut_a (
    .clk(clk), .reset(reset), .L1(L1), .L2(L2), .L3(L3), .L4(L4),
    .phase(ph_a), .locked(lk_a), .fault(ft_a), .fault_code(fc_a), .rot_count(rot_a));

  ring_monitor #(.CNT_W(8), .LOCK_N(3)) u_dut_b (
    .clk(clk), .reset(reset), .L1(L1), .L2(L2), .L3(L3), .L4(L4),
    .phase(ph_b), .locked(lk_b), .fault(ft_b), .fault_code(fc_b), .rot_count(rot_b));

  typedef struct {
    int ph;
    bit lk;
    bit ft;
    int fc;
    int rot;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode 0 waiting, 1 counting good steps, 2 locked, 3 faulted.
  int m_mode = 0, m_good = 0, m_prev = 0, m_code = 0, m_rot = 0;
  bit m_pl3 = 0;
  bit last_l3 = 0;
  int rpos = 0;
  bit [2:0] last_v = 3'b000;

  task automatic drive(input bit rst, input bit [2:0] v, input bit l4);
    int  ph;
    bit  legal;
    exp_t e;
    @(negedge clk);
    reset = rst; {L1, L2, L3} = v; L4 = l4;
    ph = ($countones(v) == 1) ? (v[2] ? 1 : (v[1] ? 2 : 3)) : 0;
    legal = (ph != 0) && (m_prev != 0) && (ph == (m_prev % 3) + 1);
    if (rst) begin
      m_mode = 0; m_good = 0; m_prev = 0; m_code = 0; m_rot = 0; m_pl3 = 0; ph = 0;
    end else begin
      if (m_mode == 0) begin
        if (ph != 0) begin m_mode = 1; m_good = 0; end
      end else if (m_mode == 1) begin
        if (ph == 0) begin m_mode = 0; m_good = 0; end
        else if (legal) begin
          m_good++;
          if (m_good == 3) m_mode = 2;
        end else m_good = 0;
      end else if (m_mode == 2) begin
        if (ph == 0)          begin m_mode = 3; m_code = 1; end
        else if (!legal)      begin m_mode = 3; m_code = 2; end
        else if (l4 != m_pl3) begin m_mode = 3; m_code = 3; end
        else if (ph == 1)     m_rot++;
      end
      m_prev = ph;
      m_pl3  = v[0];
    end
    e.ph = ph; e.lk = (m_mode == 2); e.ft = (m_mode == 3); e.fc = m_code; e.rot = m_rot;
    sb.push_back(e);
    last_l3 = v[0];
    last_v  = v;
  endtask

  task automatic do_reset(input int n);
    repeat (n) drive(1'b1, 3'b000, 1'b0);
    rpos = 0;
  endtask

  task automatic ring(input int n);
    bit [2:0] v;
    repeat (n) begin
      v = 3'b100 >> rpos;
      drive(1'b0, v, last_l3);
      rpos = (rpos + 1) % 3;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (ph_a !== 2'(e.ph) || lk_a !== e.lk || ft_a !== e.ft || fc_a !== 2'(e.fc) ||
          rot_a !== 2'(e.rot % 4) || ph_b !== 2'(e.ph) || lk_b !== e.lk || ft_b !== e.ft ||
          fc_b !== 2'(e.fc) || rot_b !== 8'(e.rot % 256)) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got ph=%0d/%0d lk=%b/%b ft=%b/%b fc=%0d/%0d rot=%0d/%0d expected ph=%0d lk=%b ft=%b fc=%0d rot=%0d",
                 $time, ph_a, ph_b, lk_a, lk_b, ft_a, ft_b, fc_a, fc_b, rot_a, rot_b,
                 e.ph, e.lk, e.ft, e.fc, e.rot);
      end
    end
  end

  initial begin
    int r;
    bit [2:0] v;
    reset = 1'b1; {L1, L2, L3, L4} = 4'b0000;

    // Clean ring: lock at third transition, two counted rotations after that.
    do_reset(2);
    settle();
    chk("reset_locked", lk_b, 0);
    chk("reset_rot", rot_b, 0);
    ring(10);
    settle();
    chk("clean_locked", lk_b, 1);
    chk("clean_rot", rot_b, 2);

    // Skip 3 -> 1 -> 3: order fault, counter frozen while ring keeps going.
    while (rpos != 0) ring(1);
    ring(1);
    drive(1'b0, 3'b001, last_l3);
    rpos = 0;
    ring(6);
    settle();
    chk("skip_code", fc_b, 2);
    chk("skip_rot", rot_b, 3);

    // Multi-hot together with a bad tap: not-one-hot wins.
    do_reset(1);
    ring(5);
    drive(1'b0, 3'b110, ~last_l3);
    settle();
    chk("multihot_code", fc_b, 1);

    // Tap mismatch on a legal step.
    do_reset(1);
    ring(5);
    drive(1'b0, 3'b001, 1'b1);
    settle();
    chk("tap_code", fc_b, 3);

    // Reset out of FAULT, then full relock.
    do_reset(1);
    settle();
    chk("fault_reset", ft_b, 0);
    ring(4);
    settle();
    chk("relock", lk_b, 1);

    // Five clean rotations: 2-bit counter wraps to 1.
    do_reset(1);
    ring(19);
    settle();
    chk("wrap_rot2", rot_a, 1);
    chk("wrap_rot8", rot_b, 5);
    chk("wrap_fault", ft_a, 0);

    // Repeat during SYNC restarts the good count.
    do_reset(1);
    drive(1'b0, 3'b100, 1'b0);
    drive(1'b0, 3'b010, 1'b0);
    drive(1'b0, 3'b010, 1'b0);
    rpos = 2;
    ring(2);
    settle();
    chk("sync_repeat_notlocked", lk_b, 0);
    ring(1);
    settle();
    chk("sync_repeat_locked", lk_b, 1);

    // Upstream held in reset: constant L1, never locks, never faults.
    do_reset(1);
    repeat (10) drive(1'b0, 3'b100, 1'b0);
    settle();
    chk("stuck_locked", lk_b, 0);
    chk("stuck_fault", ft_b, 0);

    // Randomized episodes with sparse error injection.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset($urandom_range(1, 2));
      for (int c = 0; c < 30; c++) begin
        r = $urandom_range(0, 39);
        if (r == 0) begin
          v = 3'($urandom_range(0, 7));
          drive(1'b0, v, 1'($urandom_range(0, 1)));
        end else if (r == 1) begin
          v = 3'b100 >> rpos;
          drive(1'b0, v, ~last_l3);
          rpos = (rpos + 1) % 3;
        end else if (r == 2) begin
          drive(1'b0, last_v, last_l3);
        end else if (r == 3) begin
          do_reset(1);
        end else begin
          ring(1);
        end
      end
    end

    drive(1'b1, 3'b000, 1'b0);
    settle();
    settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
